// File: rtl/synth_pkg.sv
// Shared constants, channel configuration record and arithmetic helpers for the
// synth_bank DDS block.
package synth_pkg;
    localparam int SAMPLE_W = 16;
    localparam int PHASE_W  = 16;
    localparam int AMP_FRAC = 15;

    typedef struct packed {
        logic                       en;
        logic signed [SAMPLE_W-1:0] amp;
        logic [PHASE_W-1:0]         offset;
        logic [PHASE_W-1:0]         phaseword;
    } cfg_t;

    function automatic logic signed [SAMPLE_W-1:0] saturate16(input logic signed [31:0] v);
        if (v > 32'sd32767) return 16'sh7fff;
        else if (v < -32'sd32768) return 16'sh8000;
        else return v[SAMPLE_W-1:0];
    endfunction

    // round(32767*sin(pi/2 * idx/(2^lut_bits-1))) in Q30 integer Taylor form, so the
    // first entry is exactly 0 and the last exactly full scale.
    function automatic int sine_entry(input int idx, input int lut_bits);
        longint x, term, sum, last;
        last = (longint'(1) << lut_bits) - 1;
        x    = (longint'(1686629713) * idx) / last;
        term = x;
        sum  = x;
        for (int k = 1; k <= 6; k++) begin
            term = (term * x) >>> 30;
            term = (term * x) >>> 30;
            term = -term / (2 * k * (2 * k + 1));
            sum  = sum + term;
        end
        sum = (sum * 32767 + (longint'(1) << 29)) >>> 30;
        if (sum > 32767) sum = 32767;
        if (sum < 0) sum = 0;
        return int'(sum);
    endfunction
endpackage

// File: rtl/synth_channel.sv
// One DDS channel: phase accumulator, phase register, quarter-wave sine lookup
// and amplitude scaling.
module synth_channel
    import synth_pkg::*;
#(
    parameter int LUT_BITS = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  cfg_t                       cfg,
    input  logic                       phase_clr,
    output logic signed [SAMPLE_W-1:0] prod
);
    localparam int DEPTH = 1 << LUT_BITS;

    logic [PHASE_W-1:0]         acc, ph, p;
    logic [SAMPLE_W-2:0]        rom [DEPTH];
    logic [LUT_BITS-1:0]        idx;
    logic [SAMPLE_W-2:0]        mag;
    logic                       neg_q, en_q;
    logic signed [SAMPLE_W-1:0] amp_q, scaled;
    logic signed [31:0]         full;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        localparam int VAL = sine_entry(g, LUT_BITS);
        assign rom[g] = (SAMPLE_W-1)'(VAL);
    end

    assign p   = ph + cfg.offset;
    assign idx = p[PHASE_W-2] ? ~p[PHASE_W-3 -: LUT_BITS] : p[PHASE_W-3 -: LUT_BITS];

    // phase bits below table resolution are dropped
    if (LUT_BITS < PHASE_W - 2) begin : g_lo
        logic unused_lo;
        assign unused_lo = ^p[PHASE_W-3-LUT_BITS:0];
    end

    // scale the magnitude, then apply the half-wave sign, so the wave is symmetric
    assign full   = 32'(amp_q) * 32'($signed({1'b0, mag}));
    assign scaled = full[SAMPLE_W+AMP_FRAC-1:AMP_FRAC];

    logic unused_full;
    assign unused_full = ^{full[31], full[AMP_FRAC-1:0]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc   <= '0;
            ph    <= '0;
            mag   <= '0;
            neg_q <= 1'b0;
            en_q  <= 1'b0;
            amp_q <= '0;
            prod  <= '0;
        end else begin
            acc   <= phase_clr ? '0 : acc + cfg.phaseword;
            ph    <= acc;
            mag   <= rom[idx];
            neg_q <= p[PHASE_W-1];
            en_q  <= cfg.en;
            amp_q <= cfg.amp;
            prod  <= !en_q ? '0 : (neg_q ? -scaled : scaled);
        end
    end
endmodule

// File: rtl/synth_bank.sv
// N-channel DDS bank: shadow/active configuration, per-channel generators,
// pipelined adder tree and shifted, saturated output.
module synth_bank
    import synth_pkg::*;
#(
    parameter int CHANNELS = 8,
    parameter int LUT_BITS = 8,
    parameter int LOG2CH   = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [LOG2CH-1:0] cfg_chan,
    input  logic              cfg_en,
    input  logic [15:0]       cfg_amp,
    input  logic [15:0]       cfg_offset,
    input  logic [15:0]       cfg_phaseword,
    input  logic              cfg_commit,
    input  logic              cfg_phase_clr,
    input  logic [LOG2CH:0]   out_shift,
    output logic [15:0]       results,
    output logic              out_valid
);
    localparam int STAGES = 4 + LOG2CH;
    localparam int SUM_W  = SAMPLE_W + LOG2CH;

    cfg_t [CHANNELS-1:0]                shadow, active;
    logic [CHANNELS-1:0][SAMPLE_W-1:0]  prod;
    logic [STAGES:0]                    vld_pipe;
    logic                               wr, cm;
    logic [LOG2CH:0]                    shamt;
    logic signed [SUM_W-1:0]            shifted;

    assign wr = cfg_valid && cfg_ready;
    assign cm = cfg_commit && cfg_ready;

    // a write on the commit edge lands in shadow only; active takes pre-edge shadow
    always_ff @(posedge clk) begin
        if (!reset) begin
            shadow    <= '0;
            active    <= '0;
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= !cm;
            if (cm) active <= shadow;
            if (wr) shadow[cfg_chan] <= '{en: cfg_en, amp: cfg_amp, offset: cfg_offset,
                                          phaseword: cfg_phaseword};
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        synth_channel #(.LUT_BITS(LUT_BITS)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .cfg       (active[i]),
            .phase_clr (cm && cfg_phase_clr),
            .prod      (prod[i])
        );
    end

    // level k holds CHANNELS>>k sums of 16+k bits, so no level can overflow
    for (genvar k = 0; k <= LOG2CH; k++) begin : g_lvl
        localparam int N = CHANNELS >> k;
        localparam int W = SAMPLE_W + k;
        logic signed [W-1:0] sum [N];
        if (k == 0) begin : g_leaf
            for (genvar i = 0; i < N; i++) begin : g_in
                assign sum[i] = $signed(prod[i]);
            end
        end else begin : g_add
            always_ff @(posedge clk) begin
                for (int i = 0; i < N; i++) begin
                    if (!reset) sum[i] <= '0;
                    else sum[i] <= W'(g_lvl[k-1].sum[2*i]) + W'(g_lvl[k-1].sum[2*i+1]);
                end
            end
        end
    end

    assign shamt   = (out_shift > (LOG2CH+1)'(LOG2CH)) ? (LOG2CH+1)'(LOG2CH) : out_shift;
    assign shifted = g_lvl[LOG2CH].sum[0] >>> shamt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            results  <= '0;
            vld_pipe <= '0;
        end else begin
            results  <= saturate16(32'(shifted));
            vld_pipe <= {vld_pipe[STAGES-1:0], 1'b1};
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: doc/synth_bank.md
# synth_bank

Parametrised N-channel direct digital synthesis bank: CHANNELS independent sine generators (phase accumulator, phase offset, amplitude scaling) feeding a pipelined binary adder tree, with programmable output shift and saturation to one 16-bit signed sample per clock. Per-channel configuration is written into shadow registers through a valid/ready port. A commit pulse makes all shadow registers active on the same clock edge, so multi-channel updates never produce a partially updated sample. The block sits between the control/register interface and the DAC sample path, and is the scalable replacement for the fixed 4/8-channel summing blocks.

## Interface
- CHANNELS, 8, channel count; power of two, 2..64
- LUT_BITS, 8, quarter-wave sine table address bits
- LOG2CH, $clog2(CHANNELS), derived; do not override
- clk  input  1  sample clock; all logic on rising edge
- reset  input  1  synchronous, active-low; acts at the rising edge of clk when 0
- cfg_valid  input  1  configuration write request
- cfg_ready  output  1  write accepted when cfg_valid && cfg_ready
- cfg_chan  input  LOG2CH  target channel index
- cfg_en  input  1  channel enable
- cfg_amp  input  16  signed amplitude, Q1.15
- cfg_offset  input  16  phase offset, unsigned; full circle = 2^16
- cfg_phaseword  input  16  phase increment per clock
- cfg_commit  input  1  copy all shadow registers to the active registers
- cfg_phase_clr  input  1  sampled with cfg_commit; zero all accumulators at commit
- out_shift  input  LOG2CH+1  arithmetic right shift applied to the tree sum; values > LOG2CH clamp to LOG2CH
- results  output  16  signed output sample
- out_valid  output  1  results carries pipeline-filled data

## Operation
- Reset (reset==0 at an edge) clears all of the following:
  - shadow and active registers: en=0, amp=0, offset=0, phaseword=0
  - accumulators and all pipeline registers: 0
  - outputs: results=0, out_valid=0, cfg_ready=0
- cfg_ready is 1 from the first cycle after reset is released, with one exception: it is 0 in the cycle immediately after an accepted commit.
  - A write with cfg_ready=0 is ignored.
- Accepted write: updates the shadow registers of cfg_chan only.
- Commit:
  - cfg_commit is accepted when cfg_ready=1 and is ignored otherwise.
  - Active registers take the pre-edge shadow values.
  - A write on the same edge as a commit lands in the shadow register only and is not part of that commit.
- Phase clear: if cfg_phase_clr=1 with an accepted commit, every accumulator loads 0 at that edge instead of acc+phaseword.
- Channel pipeline, 3 stages:
  - S0: acc <= acc + phaseword, mod 2^16
  - S1: p = acc + offset, mod 2^16; lut <= sine(p)
  - S2: prod <= en ? (amp*lut)>>>15 : 0, as a 16-bit signed value
- Sine function:
  - Quarter-wave table of 2^LUT_BITS entries, round(32767·sin), indexed by p[15:14] quadrant and p[13 -: LUT_BITS].
  - sine(0x0000)=0, sine(0x4000)=+32767, sine(0x8000)=0, sine(0xC000)=-32767.
- Adder tree: LOG2CH registered levels; level k sums are 16+k bits wide, so the tree never overflows.
- Output stage, 1 register: results <= saturate16(sum >>> out_shift), range -32768..+32767.
  - out_shift is sampled in this stage.
- Disabled channels contribute exactly 0. Their accumulators still advance.

## Timing
- Total latency L = 4 + LOG2CH clocks from accumulator register to results; L = 7 for CHANNELS=8.
- An accumulator value registered at edge t appears in results at edge t+L.
- out_valid rises L clocks after the first edge with reset=1 and stays 1 until the next reset.
- Commit at edge t:
  - The first sample using new amp/en/offset appears at edge t+L−1.
  - The new phaseword first affects the accumulator at edge t+1.
- out_shift change at edge t affects results at edge t+1.
- Reset mid-operation: all state is zero at the next edge. Pending shadow writes and commits are discarded.

## Structure
- Shared package synth_pkg:
  - SAMPLE_W=16, PHASE_W=16, AMP_FRAC=15
  - the cfg record typedef (en, amp, offset, phaseword)
  - the saturate16 function
- Sub-module synth_channel: accumulator, LUT, multiply (S0–S2), active cfg inputs, phase_clr input.
- The adder tree and output stage are generated in synth_bank.

## Test plan
- Reset/fill, CHANNELS=8:
  - Hold reset=0 for 3 clocks, release → results=0 and out_valid=0 for 7 clocks, then out_valid=1.
- Single tone:
  - Ch0 en=1, amp=0x7FFF, offset=0x4000, pw=0; commit; shift=0 → results=32766 steady.
  - All other channels stay 0.
- Saturation and shift, 8 channels configured identically to the single-tone case:
  - shift=0 → +32767
  - shift=3 → 32766
  - offset=0xC000 with shift=0 → −32768
  - offset=0xC000 with shift=3 → −32766
- Atomic commit:
  - Write ch0–7 shadows one per clock while results stays at the old value.
  - Single commit → results changes in exactly one step, L−1 clocks after the commit.
  - A write on the commit edge is not applied until the next commit.
  - cfg_ready=0 for one clock after the commit.
- Phase clear and rotation:
  - Ch0 pw=0x4000, offset=0, amp=0x7FFF; commit with phase_clr=1.
  - Results cycles 0, 32766, 0, −32766 with period 4.
- Mid-run reset: assert reset during the rotation test → results=0, out_valid=0, cfg_ready=0 at the next edge; all channels disabled afterward.
